// File: rtl/gds_alloc_controller.sv
// gds_alloc_controller: serialises GDS alloc/dealloc commands to the resource table, deallocs first.
// Every issued command is followed by a settle window so gds_free_size reflects it before the next decision.
module gds_alloc_controller #(
    parameter int CU_ID_WIDTH          = 6,
    parameter int WG_SLOT_ID_WIDTH     = 6,
    parameter int GDS_ID_WIDTH         = 10,
    parameter int RES_TABLE_ADDR_WIDTH = 3,
    parameter int DEALLOC_FIFO_DEPTH   = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            alloc_req_valid,
    input  logic [CU_ID_WIDTH-1:0]          alloc_req_cu_id,
    input  logic [WG_SLOT_ID_WIDTH-1:0]     alloc_req_wg_id,
    input  logic [GDS_ID_WIDTH:0]           alloc_req_gds_size,
    input  logic [RES_TABLE_ADDR_WIDTH-1:0] alloc_req_res_tbl_id,
    output logic                            alloc_ack,
    output logic                            alloc_reject,
    input  logic                            dealloc_req_valid,
    input  logic [CU_ID_WIDTH-1:0]          dealloc_req_cu_id,
    input  logic [WG_SLOT_ID_WIDTH-1:0]     dealloc_req_wg_id,
    output logic                            dealloc_req_ready,
    input  logic [GDS_ID_WIDTH:0]           gds_free_size,
    output logic                            gds_res_tbl_alloc_en,
    output logic                            gds_res_tbl_dealloc_en,
    output logic [CU_ID_WIDTH-1:0]          gds_res_tbl_cu_id,
    output logic [WG_SLOT_ID_WIDTH-1:0]     gds_res_tbl_wg_id,
    output logic [GDS_ID_WIDTH:0]           gds_res_tbl_alloc_gds_size,
    output logic [RES_TABLE_ADDR_WIDTH-1:0] gds_res_tbl_inflight_res_tbl_id,
    output logic                            gds_ctrl_busy
);
    localparam int PW = $clog2(DEALLOC_FIFO_DEPTH);
    localparam int CW = $clog2(DEALLOC_FIFO_DEPTH + 1);
    localparam int EW = CU_ID_WIDTH + WG_SLOT_ID_WIDTH;

    typedef enum logic [2:0] {IDLE, ISSUE_ALLOC, ISSUE_DEALLOC, REJECT, SETTLE} state_t;

    state_t                          state_q, state_d;
    logic [1:0]                      settle_q, settle_d;
    logic [EW-1:0]                   fifo_q [DEALLOC_FIFO_DEPTH];
    logic [PW-1:0]                   wr_q, rd_q;
    logic [CW-1:0]                   count_q;
    logic                            push, pop;
    logic [EW-1:0]                   entry, head;
    logic                            alloc_en_d, dealloc_en_d, ack_d, reject_d;
    logic [CU_ID_WIDTH-1:0]          cu_d;
    logic [WG_SLOT_ID_WIDTH-1:0]     wg_d;
    logic [GDS_ID_WIDTH:0]           size_d;
    logic [RES_TABLE_ADDR_WIDTH-1:0] tbl_d;

    assign dealloc_req_ready = !rst && count_q != CW'(DEALLOC_FIFO_DEPTH);
    assign push  = dealloc_req_valid && dealloc_req_ready;
    assign entry = {dealloc_req_cu_id, dealloc_req_wg_id};
    // An empty queue forwards the incoming push so a same-cycle dealloc still beats an alloc.
    assign head  = count_q != '0 ? fifo_q[rd_q] : entry;

    always_comb begin
        state_d      = state_q;
        settle_d     = settle_q;
        pop          = 1'b0;
        alloc_en_d   = 1'b0;
        dealloc_en_d = 1'b0;
        ack_d        = 1'b0;
        reject_d     = 1'b0;
        cu_d         = '0;
        wg_d         = '0;
        size_d       = '0;
        tbl_d        = '0;
        case (state_q)
            IDLE: begin
                if (count_q != '0 || push) begin
                    pop          = 1'b1;
                    state_d      = ISSUE_DEALLOC;
                    dealloc_en_d = 1'b1;
                    cu_d         = head[EW-1:WG_SLOT_ID_WIDTH];
                    wg_d         = head[WG_SLOT_ID_WIDTH-1:0];
                end else if (alloc_req_valid && alloc_req_gds_size <= gds_free_size) begin
                    state_d    = ISSUE_ALLOC;
                    alloc_en_d = 1'b1;
                    ack_d      = 1'b1;
                    cu_d       = alloc_req_cu_id;
                    wg_d       = alloc_req_wg_id;
                    size_d     = alloc_req_gds_size;
                    tbl_d      = alloc_req_res_tbl_id;
                end else if (alloc_req_valid) begin
                    state_d  = REJECT;
                    reject_d = 1'b1;
                end
            end
            ISSUE_ALLOC, ISSUE_DEALLOC: begin
                state_d  = SETTLE;
                settle_d = 2'd0;
            end
            REJECT: state_d = IDLE;
            SETTLE: begin
                settle_d = settle_q == 2'd2 ? 2'd0 : settle_q + 2'd1;
                state_d  = settle_q == 2'd2 ? IDLE : SETTLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q                         <= IDLE;
            settle_q                        <= '0;
            wr_q                            <= '0;
            rd_q                            <= '0;
            count_q                         <= '0;
            gds_res_tbl_alloc_en            <= 1'b0;
            gds_res_tbl_dealloc_en          <= 1'b0;
            alloc_ack                       <= 1'b0;
            alloc_reject                    <= 1'b0;
            gds_res_tbl_cu_id               <= '0;
            gds_res_tbl_wg_id               <= '0;
            gds_res_tbl_alloc_gds_size      <= '0;
            gds_res_tbl_inflight_res_tbl_id <= '0;
            gds_ctrl_busy                   <= 1'b0;
        end else begin
            state_q                         <= state_d;
            settle_q                        <= settle_d;
            wr_q                            <= push ? wr_q + PW'(1) : wr_q;
            rd_q                            <= pop ? rd_q + PW'(1) : rd_q;
            count_q                         <= count_q + CW'(push) - CW'(pop);
            gds_res_tbl_alloc_en            <= alloc_en_d;
            gds_res_tbl_dealloc_en          <= dealloc_en_d;
            alloc_ack                       <= ack_d;
            alloc_reject                    <= reject_d;
            gds_res_tbl_cu_id               <= cu_d;
            gds_res_tbl_wg_id               <= wg_d;
            gds_res_tbl_alloc_gds_size      <= size_d;
            gds_res_tbl_inflight_res_tbl_id <= tbl_d;
            gds_ctrl_busy                   <= state_d != IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_q] <= entry;
    end
endmodule

// File: tb/tb_gds_alloc_controller.sv
// tb_gds_alloc_controller: random alloc/dealloc/reset traffic against a queue-and-countdown reference.
module tb_gds_alloc_controller;
    logic        clk = 1'b0;
    logic        rst;
    logic        alloc_req_valid;
    logic [5:0]  alloc_req_cu_id, alloc_req_wg_id;
    logic [10:0] alloc_req_gds_size;
    logic [2:0]  alloc_req_res_tbl_id;
    logic        alloc_ack, alloc_reject;
    logic        dealloc_req_valid;
    logic [5:0]  dealloc_req_cu_id, dealloc_req_wg_id;
    logic        dealloc_req_ready;
    logic [10:0] gds_free_size;
    logic        gds_res_tbl_alloc_en, gds_res_tbl_dealloc_en;
    logic [5:0]  gds_res_tbl_cu_id, gds_res_tbl_wg_id;
    logic [10:0] gds_res_tbl_alloc_gds_size;
    logic [2:0]  gds_res_tbl_inflight_res_tbl_id;
    logic        gds_ctrl_busy;

    always #5 clk = ~clk;

    gds_alloc_controller dut (
        .clk                             (clk),
        .rst                             (rst),
        .alloc_req_valid                 (alloc_req_valid),
        .alloc_req_cu_id                 (alloc_req_cu_id),
        .alloc_req_wg_id                 (alloc_req_wg_id),
        .alloc_req_gds_size              (alloc_req_gds_size),
        .alloc_req_res_tbl_id            (alloc_req_res_tbl_id),
        .alloc_ack                       (alloc_ack),
        .alloc_reject                    (alloc_reject),
        .dealloc_req_valid               (dealloc_req_valid),
        .dealloc_req_cu_id               (dealloc_req_cu_id),
        .dealloc_req_wg_id               (dealloc_req_wg_id),
        .dealloc_req_ready               (dealloc_req_ready),
        .gds_free_size                   (gds_free_size),
        .gds_res_tbl_alloc_en            (gds_res_tbl_alloc_en),
        .gds_res_tbl_dealloc_en          (gds_res_tbl_dealloc_en),
        .gds_res_tbl_cu_id               (gds_res_tbl_cu_id),
        .gds_res_tbl_wg_id               (gds_res_tbl_wg_id),
        .gds_res_tbl_alloc_gds_size      (gds_res_tbl_alloc_gds_size),
        .gds_res_tbl_inflight_res_tbl_id (gds_res_tbl_inflight_res_tbl_id),
        .gds_ctrl_busy                   (gds_ctrl_busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    logic [11:0] q[$];
    int          busy_left;
    logic        e_alloc_en, e_dealloc_en, e_ack, e_rej;
    logic [5:0]  e_cu, e_wg;
    logic [10:0] e_size;
    logic [2:0]  e_tbl;

    // One clock edge of the reference: every command costs 5 cycles, a reject 2.
    task automatic model_step();
        logic [11:0] ent;
        {e_alloc_en, e_dealloc_en, e_ack, e_rej, e_cu, e_wg, e_size, e_tbl} = '0;
        if (rst) begin
            q.delete();
            busy_left = 0;
        end else begin
            if (dealloc_req_valid && q.size() != 4) q.push_back({dealloc_req_cu_id, dealloc_req_wg_id});
            if (busy_left > 0) busy_left--;
            else if (q.size() > 0) begin
                ent          = q.pop_front();
                e_dealloc_en = 1'b1;
                e_cu         = ent[11:6];
                e_wg         = ent[5:0];
                busy_left    = 4;
            end else if (alloc_req_valid) begin
                if (alloc_req_gds_size <= gds_free_size) begin
                    e_alloc_en = 1'b1;
                    e_ack      = 1'b1;
                    e_cu       = alloc_req_cu_id;
                    e_wg       = alloc_req_wg_id;
                    e_size     = alloc_req_gds_size;
                    e_tbl      = alloc_req_res_tbl_id;
                    busy_left  = 4;
                end else begin
                    e_rej     = 1'b1;
                    busy_left = 1;
                end
            end
        end
    endtask

    task automatic compare();
        check("alloc_en", gds_res_tbl_alloc_en, e_alloc_en);
        check("dealloc_en", gds_res_tbl_dealloc_en, e_dealloc_en);
        check("ack", alloc_ack, e_ack);
        check("reject", alloc_reject, e_rej);
        check("cu_id", gds_res_tbl_cu_id, e_cu);
        check("wg_id", gds_res_tbl_wg_id, e_wg);
        check("size", gds_res_tbl_alloc_gds_size, e_size);
        check("tbl_id", gds_res_tbl_inflight_res_tbl_id, e_tbl);
        check("busy", gds_ctrl_busy, busy_left > 0);
        check("ready", dealloc_req_ready, !rst && q.size() != 4);
    endtask

    task automatic drive(input int cyc);
        int mode;
        rst = cyc < 2 || $urandom_range(0, 99) == 0;
        if (rst || e_ack || e_rej) alloc_req_valid = 1'b0;
        if ($urandom_range(0, 7) == 0) gds_free_size = 11'($urandom_range(0, 1024));
        if (!rst && !alloc_req_valid && $urandom_range(0, 2) == 0) begin
            mode                 = $urandom_range(0, 4);
            alloc_req_valid      = 1'b1;
            alloc_req_cu_id      = 6'($urandom);
            alloc_req_wg_id      = 6'($urandom);
            alloc_req_res_tbl_id = 3'($urandom);
            alloc_req_gds_size   = mode == 0 ? gds_free_size :
                                   mode == 1 ? gds_free_size + 11'd1 :
                                   mode == 2 ? 11'd0 : 11'($urandom_range(0, 2047));
        end
        dealloc_req_valid = (cyc / 400) % 2 == 1 ? $urandom_range(0, 3) != 0 : $urandom_range(0, 5) == 0;
        dealloc_req_cu_id = 6'($urandom);
        dealloc_req_wg_id = 6'($urandom);
    endtask

    initial begin
        rst                  = 1'b1;
        alloc_req_valid      = 1'b0;
        alloc_req_cu_id      = '0;
        alloc_req_wg_id      = '0;
        alloc_req_gds_size   = '0;
        alloc_req_res_tbl_id = '0;
        dealloc_req_valid    = 1'b0;
        dealloc_req_cu_id    = '0;
        dealloc_req_wg_id    = '0;
        gds_free_size        = 11'd1024;
        busy_left            = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            compare();
            drive(cyc);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
